// File: rtl/jtkiwi_shr_pkg.sv
// jtkiwi_shr_pkg: shared encodings for the main/sub shared-RAM arbiter.
package jtkiwi_shr_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, GNT_M = 2'd1, GNT_S = 2'd2, RECOV = 2'd3} state_t;
   typedef enum logic {MAIN = 1'b0, SUB = 1'b1} owner_t;
   localparam logic [1:0] RD_LAT = 2'd2;
   localparam logic [1:0] WR_LAT = 2'd1;
   function automatic logic [1:0] lat(input logic rnw);
      return rnw ? RD_LAT : WR_LAT;
   endfunction
endpackage

// File: rtl/jtkiwi_shr_arb_if.sv
// jtkiwi_shr_arb_if: one requester's view of the shared RAM (CPU side drives master).
interface jtkiwi_shr_arb_if #(parameter int AW = 13, parameter int DW = 8);
   logic          cs;
   logic          rnw;
   logic [AW-1:0] addr;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;
   logic          busy;
   logic          gnt;
   modport master (output cs, rnw, addr, din, input dout, busy, gnt);
   modport slave  (input cs, rnw, addr, din, output dout, busy, gnt);
endinterface

// File: rtl/jtkiwi_shr_port.sv
// jtkiwi_shr_port: per-requester ready counter, read-data capture and wait generation.
module jtkiwi_shr_port
   import jtkiwi_shr_pkg::*;
#(
   parameter int AW = 13,
   parameter int DW = 8
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_gnt,
   input  logic          i_cs,
   input  logic          i_rnw,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_q,
   output logic [DW-1:0] o_dout,
   output logic          o_wait
);
   logic [AW-1:0] r_addr;
   logic          r_rnw;
   logic          r_gnt;
   logic [1:0]    r_cnt;
   logic          w_chg;
   logic          w_rdy;
   assign w_chg  = i_addr != r_addr || i_rnw != r_rnw;
   assign w_rdy  = i_gnt && r_cnt >= lat(i_rnw);
   // wait also drops while reset is held so the CPU is never left stalled
   assign o_wait = rst_n & i_cs & ~w_rdy;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_addr <= '0;
         r_rnw  <= 1'b1;
         r_gnt  <= 1'b0;
         r_cnt  <= '0;
         o_dout <= '0;
      end else begin
         r_addr <= i_addr;
         r_rnw  <= i_rnw;
         r_gnt  <= i_gnt;
         r_cnt  <= (!i_gnt || w_chg) ? 2'd0 : r_cnt + {1'b0, r_cnt != 2'd3};
         if (r_gnt && i_addr == r_addr) o_dout <= i_q;
      end
endmodule

// File: rtl/jtkiwi_shr_arb.sv
// jtkiwi_shr_arb: FCFS/round-robin arbiter sharing one single-port RAM between main and sub CPUs.
// Define JTKIWI_SHR_STATS_EN to add wait-cycle counters selectable on o_st_dout via i_stat_sel.
module jtkiwi_shr_arb
   import jtkiwi_shr_pkg::*;
#(
   parameter int AW       = 13,
   parameter int DW       = 8,
   parameter int RECOVERY = 1,
   parameter int MAXHOLD  = 64
)(
   input  logic            clk,
   input  logic            rst_n,
   jtkiwi_shr_arb_if.slave m_bus,
   jtkiwi_shr_arb_if.slave s_bus,
   output logic [AW-1:0]   o_ram_addr,
   output logic [DW-1:0]   o_ram_din,
   output logic            o_ram_we,
   input  logic [DW-1:0]   i_ram_q,
`ifdef JTKIWI_SHR_STATS_EN
   input  logic [1:0]      i_stat_sel,
`endif
   output logic [7:0]      o_st_dout
);
   localparam int HW = $clog2(MAXHOLD + 1);
   localparam int RW = RECOVERY > 1 ? $clog2(RECOVERY) : 1;
   state_t          r_state;
   owner_t          r_last;
   logic            r_m_gnt;
   logic            r_s_gnt;
   logic            r_hog;
   logic [HW-1:0]   r_hold;
   logic [RW-1:0]   r_rec;
   logic [7:0]      r_st;
   logic            w_pick_m;
   logic            w_pick_s;
   logic            w_m_wait;
   logic            w_s_wait;
   logic            w_hold_inc;
   logic [DW-1:0]   w_m_dout;
   logic [DW-1:0]   w_s_dout;
   logic [7:0]      w_status;
   assign w_pick_m   = m_bus.cs & (~s_bus.cs | r_last == SUB);
   assign w_pick_s   = s_bus.cs & ~w_pick_m;
   assign o_ram_addr = r_s_gnt ? s_bus.addr : m_bus.addr;
   assign o_ram_din  = r_s_gnt ? s_bus.din : m_bus.din;
   assign o_ram_we   = (r_m_gnt & m_bus.cs & ~m_bus.rnw) | (r_s_gnt & s_bus.cs & ~s_bus.rnw);
   assign m_bus.gnt  = r_m_gnt;
   assign s_bus.gnt  = r_s_gnt;
   assign m_bus.busy = w_m_wait;
   assign s_bus.busy = w_s_wait;
   assign m_bus.dout = w_m_dout;
   assign s_bus.dout = w_s_dout;
   assign w_hold_inc = (r_m_gnt & w_s_wait) | (r_s_gnt & w_m_wait);
   assign w_status   = {r_hog, r_last, w_m_wait, w_s_wait, r_m_gnt, r_s_gnt, r_state};
   assign o_st_dout  = r_st;
   jtkiwi_shr_port #(.AW(AW), .DW(DW)) u_m (
      .clk, .rst_n, .i_gnt(r_m_gnt), .i_cs(m_bus.cs), .i_rnw(m_bus.rnw),
      .i_addr(m_bus.addr), .i_q(i_ram_q), .o_dout(w_m_dout), .o_wait(w_m_wait)
   );
   jtkiwi_shr_port #(.AW(AW), .DW(DW)) u_s (
      .clk, .rst_n, .i_gnt(r_s_gnt), .i_cs(s_bus.cs), .i_rnw(s_bus.rnw),
      .i_addr(s_bus.addr), .i_q(i_ram_q), .o_dout(w_s_dout), .o_wait(w_s_wait)
   );
   // with no recovery gap the release cycle doubles as the arbitration cycle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= IDLE;
         r_last  <= SUB;
         r_m_gnt <= 1'b0;
         r_s_gnt <= 1'b0;
         r_rec   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_state <= w_pick_m ? GNT_M : w_pick_s ? GNT_S : IDLE;
               r_m_gnt <= w_pick_m;
               r_s_gnt <= w_pick_s;
            end
            GNT_M: begin
               r_last <= MAIN;
               if (!m_bus.cs) begin
                  r_state <= RECOVERY > 0 ? RECOV : s_bus.cs ? GNT_S : IDLE;
                  r_m_gnt <= 1'b0;
                  r_s_gnt <= RECOVERY == 0 && s_bus.cs;
                  r_rec   <= '0;
               end
            end
            GNT_S: begin
               r_last <= SUB;
               if (!s_bus.cs) begin
                  r_state <= RECOVERY > 0 ? RECOV : m_bus.cs ? GNT_M : IDLE;
                  r_s_gnt <= 1'b0;
                  r_m_gnt <= RECOVERY == 0 && m_bus.cs;
                  r_rec   <= '0;
               end
            end
            default: begin
               if (r_rec == RW'(RECOVERY - 1)) r_state <= IDLE;
               else r_rec <= r_rec + 1'b1;
            end
         endcase
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_hold <= '0;
         r_hog  <= 1'b0;
      end else begin
         r_hold <= w_hold_inc ? (r_hold == HW'(MAXHOLD) ? r_hold : r_hold + 1'b1) : '0;
         r_hog  <= r_hog | (w_hold_inc & r_hold == HW'(MAXHOLD - 1));
      end
`ifdef JTKIWI_SHR_STATS_EN
   logic [15:0] r_cnt_m;
   logic [15:0] r_cnt_s;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_cnt_m <= '0;
         r_cnt_s <= '0;
         r_st    <= '0;
      end else begin
         r_cnt_m <= r_cnt_m + {15'd0, w_m_wait & ~&r_cnt_m};
         r_cnt_s <= r_cnt_s + {15'd0, w_s_wait & ~&r_cnt_s};
         r_st    <= i_stat_sel == 2'd1 ? r_cnt_m[15:8] : i_stat_sel == 2'd2 ? r_cnt_s[15:8] : w_status;
      end
`else
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_st <= '0;
      else r_st <= w_status;
`endif
endmodule

// File: tb/tb_jtkiwi_shr_arb.sv
// tb_jtkiwi_shr_arb: directed vectors for the shared-RAM arbiter (RECOVERY=1 and RECOVERY=0 instances).
module tb_jtkiwi_shr_arb;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [12:0] ram_addr, ram_addr0;
   logic [7:0]  ram_din, ram_din0, ram_q, st_dout, st_dout0;
   logic        ram_we, ram_we0;
   logic [7:0]  mem [8192];
   int          n_vec = 0, n_bad = 0, we_cnt = 0, excl_bad = 0;
   logic        we_prev = 1'b0;
   logic [12:0] we_addr = '0;
`ifdef JTKIWI_SHR_STATS_EN
   logic [1:0]  stat_sel = 2'd0;
`endif
   jtkiwi_shr_arb_if #(.AW(13), .DW(8)) m_if (), s_if (), m0_if (), s0_if ();
   jtkiwi_shr_arb #(.RECOVERY(1), .MAXHOLD(64)) dut (
      .clk, .rst_n, .m_bus(m_if), .s_bus(s_if),
      .o_ram_addr(ram_addr), .o_ram_din(ram_din), .o_ram_we(ram_we), .i_ram_q(ram_q),
`ifdef JTKIWI_SHR_STATS_EN
      .i_stat_sel(stat_sel),
`endif
      .o_st_dout(st_dout)
   );
   jtkiwi_shr_arb #(.RECOVERY(0), .MAXHOLD(64)) dut0 (
      .clk, .rst_n, .m_bus(m0_if), .s_bus(s0_if),
      .o_ram_addr(ram_addr0), .o_ram_din(ram_din0), .o_ram_we(ram_we0), .i_ram_q(8'h00),
`ifdef JTKIWI_SHR_STATS_EN
      .i_stat_sel(stat_sel),
`endif
      .o_st_dout(st_dout0)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_q <= mem[ram_addr];
   end
   always @(negedge clk) begin
      if (ram_we && !we_prev) begin
         we_cnt++;
         we_addr = ram_addr;
      end
      we_prev = ram_we;
      if (ram_we0 && !(m0_if.gnt ^ s0_if.gnt)) excl_bad++;
   end
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic nc(input int n);
      repeat (n) @(negedge clk);
   endtask
   initial begin
      {m_if.cs, m_if.rnw, m_if.addr, m_if.din} = '0;
      {s_if.cs, s_if.rnw, s_if.addr, s_if.din} = '0;
      {m0_if.cs, m0_if.rnw, m0_if.addr, m0_if.din} = '0;
      {s0_if.cs, s0_if.rnw, s0_if.addr, s0_if.din} = '0;
      mem[13'h0123] = 8'h5A;
      mem[13'h0010] = 8'h77;
      nc(2);
      chk("rst_m_gnt", m_if.gnt, 0);
      chk("rst_s_gnt", s_if.gnt, 0);
      chk("rst_m_dout", m_if.dout, 0);
      chk("rst_s_dout", s_if.dout, 0);
      chk("rst_st", st_dout, 0);
      chk("rst_we", ram_we, 0);
      rst_n = 1'b1;
      nc(2);
      // main-only read
      m_if.rnw = 1'b1; m_if.addr = 13'h0123; m_if.cs = 1'b1;
      nc(1);
      chk("t1_m_gnt_c1", m_if.gnt, 1);
      chk("t1_m_wait_c1", m_if.busy, 1);
      chk("t1_s_gnt_c1", s_if.gnt, 0);
      nc(1);
      chk("t1_m_wait_c2", m_if.busy, 1);
      nc(1);
      chk("t1_m_wait_c3", m_if.busy, 0);
      chk("t1_m_dout_c3", m_if.dout, 8'h5A);
      chk("t1_s_gnt_c3", s_if.gnt, 0);
      m_if.cs = 1'b0;
      nc(1);
      chk("t1_st_c4", st_dout, 8'h09);
      nc(1);
      // sub write vs main read tie; last=MAIN so sub goes first
      we_cnt = 0;
      s_if.rnw = 1'b0; s_if.addr = 13'h1FFF; s_if.din = 8'hC3; s_if.cs = 1'b1;
      m_if.rnw = 1'b1; m_if.addr = 13'h1FFF; m_if.cs = 1'b1;
      nc(1);
      chk("t2_s_gnt_c1", s_if.gnt, 1);
      chk("t2_m_gnt_c1", m_if.gnt, 0);
      chk("t2_we_c1", ram_we, 1);
      chk("t2_addr_c1", ram_addr, 13'h1FFF);
      chk("t2_din_c1", ram_din, 8'hC3);
      chk("t2_m_wait_c1", m_if.busy, 1);
      nc(1);
      chk("t2_s_wait_c2", s_if.busy, 0);
      s_if.cs = 1'b0;
      nc(1);
      chk("t2_s_gnt_c3", s_if.gnt, 0);
      chk("t2_m_gnt_c3", m_if.gnt, 0);
      chk("t2_we_c3", ram_we, 0);
      nc(1);
      chk("t2_m_gnt_c4", m_if.gnt, 0);
      chk("t2_st_c4", st_dout, 8'h63);
      nc(1);
      chk("t2_m_gnt_c5", m_if.gnt, 1);
      nc(2);
      chk("t2_m_dout_c7", m_if.dout, 8'hC3);
      chk("t2_m_wait_c7", m_if.busy, 0);
      m_if.cs = 1'b0;
      chk("t2_we_pulses", we_cnt[15:0], 1);
      chk("t2_we_addr", we_addr, 13'h1FFF);
      nc(2);
      // tie after reset, then alternation
      rst_n = 1'b0;
      nc(1);
      rst_n = 1'b1;
      nc(1);
      m_if.addr = 13'h0123; m_if.rnw = 1'b1; m_if.cs = 1'b1;
      s_if.addr = 13'h0010; s_if.rnw = 1'b1; s_if.cs = 1'b1;
      nc(1);
      chk("t3_m_gnt_c1", m_if.gnt, 1);
      chk("t3_s_gnt_c1", s_if.gnt, 0);
      chk("t3_s_wait_c1", s_if.busy, 1);
      nc(2);
      chk("t3_m_dout_c3", m_if.dout, 8'h5A);
      m_if.cs = 1'b0;
      nc(3);
      chk("t3_s_gnt_c6", s_if.gnt, 1);
      chk("t3_m_gnt_c6", m_if.gnt, 0);
      nc(2);
      chk("t3_s_dout_c8", s_if.dout, 8'h77);
      chk("t3_s_wait_c8", s_if.busy, 0);
      s_if.cs = 1'b0;
      nc(2);
      m_if.cs = 1'b1; s_if.cs = 1'b1;
      nc(1);
      chk("t3_alt_m_gnt", m_if.gnt, 1);
      chk("t3_alt_s_gnt", s_if.gnt, 0);
      m_if.cs = 1'b0; s_if.cs = 1'b0;
      nc(3);
      // RECOVERY=0 instance: sub granted right after main releases
      m0_if.rnw = 1'b1; m0_if.addr = 13'h0003; m0_if.cs = 1'b1;
      nc(1);
      chk("t4_m_gnt_c1", m0_if.gnt, 1);
      s0_if.rnw = 1'b0; s0_if.addr = 13'h0005; s0_if.din = 8'h09; s0_if.cs = 1'b1;
      nc(1);
      chk("t4_s_gnt_c2", s0_if.gnt, 0);
      chk("t4_s_wait_c2", s0_if.busy, 1);
      nc(1);
      chk("t4_m_wait_c3", m0_if.busy, 0);
      m0_if.cs = 1'b0;
      nc(1);
      chk("t4_s_gnt_c4", s0_if.gnt, 1);
      chk("t4_m_gnt_c4", m0_if.gnt, 0);
      chk("t4_we_c4", ram_we0, 1);
      chk("t4_addr_c4", ram_addr0, 13'h0005);
      nc(1);
      chk("t4_s_wait_c5", s0_if.busy, 0);
      s0_if.cs = 1'b0;
      nc(2);
      chk("t4_we_excl", excl_bad[15:0], 0);
      // hog flag: main holds 70 cycles while sub waits
      rst_n = 1'b0;
      nc(1);
      rst_n = 1'b1;
      nc(1);
      m_if.cs = 1'b1; s_if.cs = 1'b1;
      nc(1);
      chk("t5_m_gnt", m_if.gnt, 1);
      nc(59);
      chk("t5_hog_c60", st_dout[7], 0);
      nc(8);
      chk("t5_hog_c68", st_dout[7], 1);
      chk("t5_s_gnt_c68", s_if.gnt, 0);
      chk("t5_s_wait_c68", s_if.busy, 1);
      nc(2);
      m_if.cs = 1'b0;
      nc(3);
      chk("t5_s_gnt_c73", s_if.gnt, 1);
      chk("t5_hog_sticky", st_dout[7], 1);
      // reset during sub write grant
      nc(1);
      s_if.rnw = 1'b0; s_if.addr = 13'h0020; s_if.din = 8'hAA;
      nc(1);
      chk("t6_we_pre", ram_we, 1);
      chk("t6_s_gnt_pre", s_if.gnt, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_s_gnt_rst", s_if.gnt, 0);
      chk("t6_s_wait_rst", s_if.busy, 0);
      chk("t6_we_rst", ram_we, 0);
      chk("t6_st_rst", st_dout, 0);
      m_if.cs = 1'b1;
      nc(1);
      rst_n = 1'b1;
      nc(1);
      chk("t6_m_gnt_tie", m_if.gnt, 1);
      chk("t6_s_gnt_tie", s_if.gnt, 0);
      m_if.cs = 1'b0; s_if.cs = 1'b0;
      nc(3);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/jtkiwi_shr_arb.md
Name: jtkiwi_shr_arb

Overview:
- Arbiter and sequencer for the 8 kB main/sub shared RAM, implemented as one single-port synchronous RAM instead of a dual-port one.
- Two requesters compete for it: the main Z80 (port m_) and the sound/sub CPU (port s_).
- Grants are first-come first-served, with round-robin on ties, a programmable recovery gap and per-requester wait/ready signalling.
- It replaces the ad-hoc mshramen/sshramen flip-flops. Its wait outputs feed the CPU dev_busy inputs.

Parameters:
- AW, 13, address width
- DW, 8, data width
- RECOVERY, 1, idle cycles forced between two grants (0..3)
- MAXHOLD, 64, grant cycles after which a waiting peer raises the hog flag

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m_cs  in  1  main request, held until the access completes
- m_rnw  in  1  main read(1)/write(0)
- m_addr  in  AW  main address
- m_din  in  DW  main write data
- m_dout  out  DW  main read data
- m_wait  out  1  main stall
- m_gnt  out  1  main owns RAM
- s_cs, s_rnw, s_addr, s_din, s_dout, s_wait, s_gnt  same as m_ for the sub CPU
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_we  out  1  RAM write enable
- ram_q  in  DW  RAM read data, 1-cycle latency
- st_dout  out  8  status/debug byte

Behaviour:
- Reset:
  - state=IDLE, m_gnt=s_gnt=0, m_dout=s_dout=0.
  - last=SUB, so main wins the first tie.
  - Hold and recovery counters cleared; st_dout=0.
- States: IDLE, GNT_M, GNT_S, RECOV. Grants are registered.
- IDLE:
  - Only m_cs → GNT_M next cycle; only s_cs → GNT_S.
  - Both → grant the requester that is not `last`.
  - Neither → stay in IDLE.
- GNT_x:
  - Held while x_cs=1; last<=x.
  - When x_cs falls: RECOV if RECOVERY>0, else IDLE. In the RECOVERY=0 case, IDLE arbitration happens in the same cycle, so a waiting peer can be granted in the very next cycle.
- RECOV: counts RECOVERY cycles, then goes to IDLE. New requests only queue (wait=1).
- Mux and write:
  - ram_addr/ram_din/ram_we are combinational from the granted port.
  - ram_we = gnt_x & x_cs & ~x_rnw. It is 0 when no grant is active (ram_addr=m_addr then).
- Ready:
  - Per-port 2-bit ready counter, cleared whenever the grant is absent or x_addr/x_rnw change during a grant.
  - rdy_x = 1 after 1 grant cycle for a write, or 2 grant cycles for a read.
  - x_wait = x_cs & ~rdy_x (combinational).
- Read data:
  - x_dout <= ram_q on each cycle where gnt_x was high the previous cycle and the address is unchanged.
  - x_dout holds otherwise.
- Example latency, main read from IDLE: m_cs at cycle 0 → m_gnt at cycle 1 → m_dout valid and m_wait=0 at cycle 3.
- Simultaneous drop and new request: the falling port completes normally. The other port goes through RECOV, then is granted.
- x_cs dropping before rdy: the access is abandoned, with no write if ram_we never pulsed. The state machine proceeds as a normal release.
- Hold counter:
  - Counts grant cycles while the peer waits; saturates at MAXHOLD.
  - hog flag is sticky until reset. It is set when the count reaches MAXHOLD. There is no preemption.
- st_dout = {hog, last, m_wait, s_wait, m_gnt, s_gnt, state[1:0]}.
- Reset asserted mid-access: all outputs drop asynchronously and any in-flight write is lost.

Optional Feature:
- Macro: JTKIWI_SHR_STATS_EN.
- Defined: adds two 16-bit saturating counters of contention cycles, one counting cycles with m_wait=1 and one with s_wait=1. They clear on reset.
  - st_dout is replaced by the selected counter's high byte.
  - An extra input `stat_sel`[1:0] selects what st_dout shows: 0 = normal status, 1 = main counter, 2 = sub counter.
- Undefined: no counters and no stat_sel port; st_dout is as described above.

Decomposition:
- Package jtkiwi_shr_pkg: state encodings (IDLE=0, GNT_M=1, GNT_S=2, RECOV=3), owner encodings (MAIN=0, SUB=1), ready thresholds (RD_LAT=2, WR_LAT=1).
- Sub-module jtkiwi_shr_port: per-requester ready counter, address-change detect, dout capture and wait generation. It is instantiated twice; the FSM and mux stay in the top.

Test Plan:
- Main-only read, RECOVERY=1, RAM[0x0123]=0x5A: m_cs at t0 → m_gnt t1, m_dout=0x5A and m_wait=0 at t3; s_gnt stays 0.
- Sub write 0xC3 to 0x1FFF, then a main read of 0x1FFF: exactly one ram_we pulse with ram_addr=0x1FFF. Main is granted after 1 RECOV cycle and reads 0xC3.
- Both cs rise in the same cycle after reset: main is granted first (last=SUB). After main releases and RECOV, sub is granted. A repeated tie then goes to main (alternation).
- RECOVERY=0: back-to-back m then s requests give s_gnt the cycle after m_cs falls, with no idle gap. ram_we is never asserted to both ports.
- Main holds cs for 70 cycles while sub waits, MAXHOLD=64: hog=1 (st_dout[7]) from the 64th cycle and stays set after release. Sub is then granted.
- Reset pulse during the sub's write grant: gnt, wait and ram_we go to 0 immediately. After release, a main-first tie resolution is observed again.
